// File: rtl/aca_ii_error_recovery.sv
// Error detection and recovery stage for the ACA-II approximate adder.
// Accepts the operands together with the speculative sum. When no block can be
// mis-speculated, the speculative result is forwarded after one cycle.
// Otherwise the stage walks every speculative block in turn, one block per
// cycle, and adds the carry that the speculation missed.
module aca_ii_error_recovery #(
  parameter int N = 16,
  parameter int R = 4,
  parameter int P = 4,
  localparam int M = (N - R - P) / R,
  localparam int CW = (M < 1) ? 1 : $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N:1]    A,
  input  logic [N:1]    B,
  input  logic          CIN,
  input  logic [N:1]    SUM_APPROX,
  input  logic          COUT_APPROX,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:1]    SUM,
  output logic          COUT,
  output logic          err_detected,
  output logic [CW-1:0] corr_count
);

  typedef enum logic [1:0] {IDLE, CORR, DONE} state_t;

  state_t        state, state_nx;
  logic [N:1]    a_q, b_q, s_q;
  logic [CW-1:0] k_q, cnt_q, cnt_nx;
  logic          any_p, fix, last, cout_fix;
  logic [N:1]    s_fix;

  // CIN only affects block 0, which the approximate adder already gets right.
  logic unused_cin;
  assign unused_cin = CIN;

  // Lowest result bit (1-based) of speculative block k.
  function automatic int blk_lsb(input int k);
    return R + P + (k - 1) * R + 1;
  endfunction

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // A block can only be wrong if its whole prediction window propagates.
  always_comb begin
    any_p = 1'b0;
    for (int j = 1; j <= M; j++) begin
      if (&(A[blk_lsb(j)-1 -: P] ^ B[blk_lsb(j)-1 -: P])) any_p = 1'b1;
    end
  end

  // Correction of the block currently selected by k_q; lower bits are exact.
  always_comb begin
    s_fix = s_q;
    fix   = 1'b0;
    for (int j = 1; j <= M; j++) begin
      if (k_q == CW'(j)) begin
        if (maj(a_q[blk_lsb(j)-1], b_q[blk_lsb(j)-1],
                a_q[blk_lsb(j)-1] ^ b_q[blk_lsb(j)-1] ^ s_q[blk_lsb(j)-1]) &
            ~(a_q[blk_lsb(j)] ^ b_q[blk_lsb(j)] ^ s_q[blk_lsb(j)])) begin
          fix = 1'b1;
          s_fix[blk_lsb(j)+R-1 -: R] = s_q[blk_lsb(j)+R-1 -: R] + R'(1);
        end
      end
    end
    cnt_nx   = cnt_q + CW'(fix);
    last     = (k_q == CW'(M));
    cout_fix = maj(a_q[N], b_q[N], a_q[N] ^ b_q[N] ^ s_fix[N]);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = any_p ? CORR : DONE;
      end
      CORR: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Working copy of operands and the sum being corrected; no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= A;
      b_q <= B;
      s_q <= SUM_APPROX;
    end else if (state == CORR) begin
      s_q <= s_fix;
    end
  end

  // Block walk counters and the held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q          <= '0;
      cnt_q        <= '0;
      SUM          <= '0;
      COUT         <= 1'b0;
      err_detected <= 1'b0;
      corr_count   <= '0;
    end else if (state == IDLE && in_valid) begin
      k_q   <= CW'(1);
      cnt_q <= '0;
      if (!any_p) begin
        SUM          <= SUM_APPROX;
        COUT         <= COUT_APPROX;
        err_detected <= 1'b0;
        corr_count   <= '0;
      end
    end else if (state == CORR) begin
      k_q   <= k_q + CW'(1);
      cnt_q <= cnt_nx;
      if (last) begin
        SUM          <= s_fix;
        COUT         <= cout_fix;
        err_detected <= (cnt_nx != '0);
        corr_count   <= cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_aca_ii_error_recovery.sv
// Bench for aca_ii_error_recovery: directed cases, back-pressure, reset
// during correction, and random operands against an arithmetic model.
module tb_aca_ii_error_recovery;
  localparam int N  = 16;
  localparam int R  = 4;
  localparam int P  = 4;
  localparam int M  = (N - R - P) / R;
  localparam int CW = (M < 1) ? 1 : $clog2(M + 1);

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic [N-1:0]  A = '0, B = '0, SUM_APPROX = '0;
  logic          CIN = 0, COUT_APPROX = 0;
  logic          out_valid;
  logic          out_ready = 0;
  logic [N-1:0]  SUM;
  logic          COUT;
  logic          err_detected;
  logic [CW-1:0] corr_count;

  int total = 0;
  int bad   = 0;

  aca_ii_error_recovery #(.N(N), .R(R), .P(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CIN(CIN), .SUM_APPROX(SUM_APPROX), .COUT_APPROX(COUT_APPROX),
    .out_valid(out_valid), .out_ready(out_ready), .SUM(SUM), .COUT(COUT),
    .err_detected(err_detected), .corr_count(corr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint msk(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  // ACA-II: block 0 adds the low R+P bits with CIN; each speculative block adds
  // its R+P-bit window with carry-in 0 and keeps the top R bits.
  task automatic aca_model(input longint a, input longint b, input bit c,
                           output longint s, output bit co);
    longint lo, w;
    lo = (a & msk(R+P)) + (b & msk(R+P)) + c;
    s  = lo & msk(R+P);
    co = (lo >> (R+P)) & 1;
    for (int k = 1; k <= M; k++) begin
      int base = R + P + (k-1)*R;
      w  = ((a >> (base-P)) & msk(R+P)) + ((b >> (base-P)) & msk(R+P));
      s |= ((w >> P) & msk(R)) << base;
      if (k == M) co = (w >> (R+P)) & 1;
    end
  endtask

  // Reference result: exact sum plus the count of blocks whose speculative
  // carry-in was 0 while the true carry-in was 1.
  task automatic ref_model(input longint a, input longint b, input bit c,
                           output longint es, output bit ec, output int en, output int elat);
    longint ex, aw, bw;
    bit any, tc, sc;
    ex = a + b + c;
    es = ex & msk(N);
    ec = (ex >> N) & 1;
    en = 0; any = 0;
    for (int k = 1; k <= M; k++) begin
      int base = R + P + (k-1)*R;
      aw = (a >> (base-P)) & msk(P);
      bw = (b >> (base-P)) & msk(P);
      if ((aw ^ bw) == msk(P)) any = 1;
      tc = ((a ^ b ^ ex) >> base) & 1;
      sc = ((aw + bw) >> P) & 1;
      if (tc && !sc) en++;
    end
    elat = any ? 1 + M : 1;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input logic [N-1:0] sa, input logic ca,
                        input logic [N-1:0] es, input logic ec, input int en,
                        input int elat, input int hold);
    int lat;
    A = a; B = b; CIN = c; SUM_APPROX = sa; COUT_APPROX = ca; in_valid = 1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    A = N'($urandom); B = N'($urandom); SUM_APPROX = N'($urandom); COUT_APPROX = $urandom;
    lat = 1;
    while (!out_valid && lat <= M + 3) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("sum", SUM, es);
    check("cout", COUT, ec);
    check("corr_count", corr_count, en);
    check("err_detected", err_detected, en != 0);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 0;
      in_valid = 1;
      A = N'($urandom); B = N'($urandom);
      @(posedge clk); #1;
      in_valid = 0;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_sum", SUM, es);
      check("hold_cout", COUT, ec);
      check("hold_cnt", corr_count, en);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("drop_valid", out_valid, 0);
    check("back_idle", in_ready, 1);
  endtask

  task automatic run_rand(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input int hold);
    longint s, es;
    bit co, ec;
    int en, elat;
    aca_model(a, b, c, s, co);
    ref_model(a, b, c, es, ec, en, elat);
    run_op(a, b, c, N'(s), co, N'(es), ec, en, elat, hold);
  endtask

  initial begin
    longint s;
    bit co;
    logic [N-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", SUM, 0);
    check("rst_cout", COUT, 0);
    check("rst_err", err_detected, 0);
    check("rst_cnt", corr_count, 0);
    rst = 0;
    @(posedge clk); #1;

    aca_model(16'h0001, 16'h0002, 0, s, co);
    run_op(16'h0001, 16'h0002, 0, N'(s), co, 16'h0003, 0, 0, 1, 0);
    run_op(16'h00FF, 16'h0001, 0, 16'h0000, 0, 16'h0100, 0, 1, 3, 0);
    run_op(16'hFFFF, 16'h0001, 0, 16'hFF00, 0, 16'h0000, 1, 2, 3, 0);
    aca_model(16'h00FF, 16'h0000, 1, s, co);
    run_op(16'h00FF, 16'h0000, 1, N'(s), co, 16'h0100, 0, 1, 3, 5);

    // Reset in the first correction cycle discards the operation.
    A = 16'hFFFF; B = 16'h0001; CIN = 0; SUM_APPROX = 16'hFF00; COUT_APPROX = 0;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_sum", SUM, 0);
    check("mid_rst_cout", COUT, 0);
    check("mid_rst_err", err_detected, 0);
    check("mid_rst_cnt", corr_count, 0);
    rst = 0;
    @(posedge clk); #1;
    aca_model(16'h0001, 16'h0002, 0, s, co);
    run_op(16'h0001, 16'h0002, 0, N'(s), co, 16'h0003, 0, 0, 1, 0);

    for (int i = 0; i < 1500; i++) begin
      ra = N'($urandom);
      case ($urandom_range(0, 2))
        0: rb = N'($urandom);
        1: rb = ~ra ^ N'($urandom_range(0, 15));
        default: rb = (~ra & N'($urandom)) | N'($urandom_range(0, 255));
      endcase
      run_rand(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
